alu_datapath: RTL and testbench

ALU_DATAPATH -- requirements
Module: alu_datapath

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_adder.sv | 26 ++
 rtl/alu_datapath.sv | 106 ++++++++++
 tb/tb_alu_datapath.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shift/add ALU datapath: widths, control-word bit
// indices, the operation enum and the operand-writer conflict check.
package alu_pkg;

  localparam int WIDTH = 8;
  localparam int NCTRL = 11;

  localparam int C_LOAD_A  = 0;
  localparam int C_LOAD_M  = 1;
  localparam int C_ADD     = 2;
  localparam int C_SUB     = 3;
  localparam int C_SHL     = 4;
  localparam int C_INC_CNT = 5;
  localparam int C_QBIT    = 6;
  localparam int C_OUT     = 7;
  localparam int C_CLEAR   = 8;
  localparam int C_ASR     = 9;
  localparam int C_FLAGS   = 10;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } alu_op_e;

  // Bits that write A, Q or Qm1; two of them in one cycle is a sequencing bug.
  localparam logic [NCTRL-1:0] WRITER_MASK = 11'b011_0101_1101;

  function automatic logic multi_writer(input logic [NCTRL-1:0] cw);
    logic [NCTRL-1:0] w;
    w = cw & WRITER_MASK;
    return (w & (w - 11'd1)) != '0;
  endfunction

endpackage

// File: rtl/alu_adder.sv
// Combinational add/subtract of two operands with carry-out and signed
// overflow; subtraction is a + ~b + 1.
module alu_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_full;

  assign w_b    = i_sub ? ~i_b : i_b;
  assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_sub};

  assign o_sum      = w_full[WIDTH-1:0];
  assign o_carry    = w_full[WIDTH];
  // Overflow: both addends share a sign that the result does not.
  assign o_overflow = (i_a[WIDTH-1] == w_b[WIDTH-1]) &&
                      (w_full[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_datapath.sv
// Register datapath for shift/add multiply and restoring-style divide, driven
// one micro-operation bit per control-word bit by an external control unit.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCTRL-1:0]   c,
  input  logic [WIDTH-1:0]   data_in,
  output logic [2*WIDTH-1:0] data_out,
  output logic               out_valid,
  output logic               q_minus_one,
  output logic               q_zero,
  output logic               a_seven,
  output logic               cnt_7,
  output logic               carry,
  output logic               overflow,
  output logic               conflict_err
);

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_m;
  logic               r_qm1;
  logic [2:0]         r_count;
  logic [2*WIDTH-1:0] r_data_out;
  logic               r_out_valid;
  logic               r_carry;
  logic               r_overflow;
  logic               r_conflict;

  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_ovf;
  logic               w_conflict;

  assign w_conflict = multi_writer(c);

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a       (r_a),
    .i_b       (r_m),
    .i_sub     (c[C_SUB]),
    .o_sum     (w_sum),
    .o_carry   (w_cout),
    .o_overflow(w_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_qm1       <= 1'b0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_conflict  <= 1'b0;
    end else begin
      r_out_valid <= c[C_OUT];
      if (c[C_OUT]) r_data_out <= {r_a, r_q};
      if (c[C_LOAD_M]) r_m <= data_in;

      if (c[C_FLAGS]) begin
        r_carry    <= w_cout;
        r_overflow <= w_ovf;
      end

      // A suppressed clear must not zero COUNT either; an increment still applies.
      if (c[C_CLEAR] && !w_conflict) r_count <= '0;
      else if (c[C_INC_CNT])         r_count <= r_count + 3'd1;

      if (w_conflict) begin
        r_conflict <= 1'b1;
      end else if (c[C_LOAD_A]) begin
        r_a <= data_in;
      end else if (c[C_ADD] || c[C_SUB]) begin
        r_a <= w_sum;
      end else if (c[C_SHL]) begin
        {r_a, r_q} <= {r_a[WIDTH-2:0], r_q, 1'b0};
      end else if (c[C_QBIT]) begin
        r_q[0] <= ~r_a[WIDTH-1];
      end else if (c[C_CLEAR]) begin
        r_q   <= r_a;
        r_a   <= '0;
        r_qm1 <= 1'b0;
      end else if (c[C_ASR]) begin
        {r_a, r_q, r_qm1} <= {r_a[WIDTH-1], r_a, r_q};
      end
    end
  end

  assign data_out     = r_data_out;
  assign out_valid    = r_out_valid;
  assign q_minus_one  = r_qm1;
  assign q_zero       = r_q[0];
  assign a_seven      = r_a[WIDTH-1];
  assign cnt_7        = (r_count == 3'd7);
  assign carry        = r_carry;
  assign overflow     = r_overflow;
  assign conflict_err = r_conflict;

endmodule

// File: tb/tb_alu_datapath.sv
// Scoreboard bench for alu_datapath: directed scenarios then random single-writer
// control words, checked against an arithmetic reference model.
module tb_alu_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] c = '0;
  logic [7:0]  data_in = '0;
  logic [15:0] data_out;
  logic        out_valid, q_minus_one, q_zero, a_seven, cnt_7;
  logic        carry, overflow, conflict_err;

  alu_datapath #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .c(c), .data_in(data_in),
    .data_out(data_out), .out_valid(out_valid),
    .q_minus_one(q_minus_one), .q_zero(q_zero), .a_seven(a_seven), .cnt_7(cnt_7),
    .carry(carry), .overflow(overflow), .conflict_err(conflict_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sb[$];

  int mA, mQ, mM, mQm1, mCnt, mCarry, mOvf, mErr;
  int writer_bits[7] = '{0, 2, 3, 4, 6, 8, 9};

  function automatic logic [10:0] cb(input int n);
    logic [10:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mA = 0; mQ = 0; mM = 0; mQm1 = 0; mCnt = 0; mCarry = 0; mOvf = 0; mErr = 0;
  endtask

  task automatic model_step(input logic [10:0] cw, input int d);
    int nw, oA, oQ, oM, oQm1, b, s, sa, sm, sr, v;
    oA = mA; oQ = mQ; oM = mM; oQm1 = mQm1;
    nw = 0;
    foreach (writer_bits[i]) if (cw[writer_bits[i]]) nw++;
    if (cw[7]) sb.push_back(16'(oA * 256 + oQ));
    if (cw[10]) begin
      b  = cw[3] ? (255 - oM) : oM;
      s  = oA + b + int'(cw[3]);
      sa = (oA >= 128) ? oA - 256 : oA;
      sm = (oM >= 128) ? oM - 256 : oM;
      sr = cw[3] ? sa - sm : sa + sm;
      mCarry = (s > 255) ? 1 : 0;
      mOvf   = (sr < -128 || sr > 127) ? 1 : 0;
    end
    if (cw[8] && nw <= 1) mCnt = 0;
    else if (cw[5])       mCnt = (mCnt + 1) % 8;
    if (nw > 1) mErr = 1;
    else if (cw[0]) mA = d;
    else if (cw[2]) mA = (oA + oM) % 256;
    else if (cw[3]) mA = (oA - oM + 256) % 256;
    else if (cw[4]) begin
      v = ((oA * 256 + oQ) * 2) % 65536;
      mA = v / 256; mQ = v % 256;
    end
    else if (cw[6]) mQ = (oQ / 2) * 2 + ((oA >= 128) ? 0 : 1);
    else if (cw[8]) begin
      mQ = oA; mA = 0; mQm1 = 0;
    end
    else if (cw[9]) begin
      v = (oA * 512 + oQ * 2 + oQm1) / 2 + ((oA >= 128) ? 65536 : 0);
      mA = v / 512; mQ = (v / 2) % 256; mQm1 = v % 2;
    end
    if (cw[1]) mM = d;
  endtask

  task automatic chk_status(input string name);
    logic [6:0] e;
    e = {mQm1 != 0, (mQ % 2) != 0, mA >= 128, mCnt == 7, mCarry != 0, mOvf != 0, mErr != 0};
    chk(name, {q_minus_one, q_zero, a_seven, cnt_7, carry, overflow, conflict_err}, e);
  endtask

  task automatic cyc(input logic [10:0] cw, input logic [7:0] d);
    @(negedge clk);
    c = cw;
    data_in = d;
    model_step(cw, int'(d));
    @(posedge clk);
    #1;
    c = '0;
    chk_status("status");
  endtask

  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_valid_unexpected: got data_out 0x%0h with nothing expected at %0t", data_out, $time);
      end else begin
        chk("data_out", data_out, sb.pop_front());
      end
    end
  end

  initial begin
    logic [10:0] cw;
    int sel;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data_out", data_out, 16'h0000);
    chk("reset_out_valid", out_valid, 1'b0);
    chk_status("reset_status");
    @(negedge clk);
    rst = 1'b1;

    // Add with flags, then output
    cyc(cb(0), 8'h25);
    cyc(cb(1), 8'h5A);
    cyc(cb(2) | cb(10), 8'h00);
    chk("add_carry", carry, 1'b0);
    chk("add_overflow", overflow, 1'b0);
    cyc(cb(7), 8'h00);
    chk("add_out_valid", out_valid, 1'b1);
    chk("add_data_out", data_out, 16'h7F00);
    cyc('0, 8'h00);
    chk("add_out_valid_drop", out_valid, 1'b0);

    // Subtract with signed overflow
    cyc(cb(0), 8'h80);
    cyc(cb(1), 8'h01);
    cyc(cb(3) | cb(10), 8'h00);
    chk("sub_carry", carry, 1'b1);
    chk("sub_overflow", overflow, 1'b1);
    cyc(cb(7), 8'h00);
    cyc('0, 8'h00);

    // Clear-transfer then arithmetic shift right
    cyc(cb(0), 8'h03);
    cyc(cb(8), 8'h00);
    cyc(cb(9), 8'h00);
    chk("asr_q_zero", q_zero, 1'b1);
    chk("asr_qm1", q_minus_one, 1'b1);
    cyc(cb(7), 8'h00);
    cyc('0, 8'h00);

    // Counter wrap
    cyc(cb(8), 8'h00);
    for (int i = 1; i <= 8; i++) begin
      cyc(cb(5), 8'h00);
      if (i == 7) chk("cnt_7_after_7", cnt_7, 1'b1);
      if (i == 8) chk("cnt_7_after_8", cnt_7, 1'b0);
    end

    // Writer conflict
    cyc(cb(0), 8'h3C);
    cyc(cb(1), 8'h11);
    cyc(cb(2) | cb(9), 8'h00);
    chk("conflict_err_set", conflict_err, 1'b1);
    cyc(cb(7), 8'h00);
    repeat (5) cyc('0, 8'h00);
    chk("conflict_err_sticky", conflict_err, 1'b1);

    // Reset while out_valid is high
    cyc(cb(0), 8'h11);
    cyc(cb(7), 8'h00);
    chk("pre_reset_out_valid", out_valid, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_data_out", data_out, 16'h0000);
    model_reset();
    sb.delete();
    chk_status("async_status");
    @(negedge clk);
    rst = 1'b1;
    cyc(cb(0) | cb(7), 8'h42);
    cyc(cb(7), 8'h00);
    cyc('0, 8'h00);

    // Random single-writer control words
    for (int n = 0; n < 400; n++) begin
      cw = '0;
      sel = $urandom_range(0, 7);
      if (sel > 0) cw = cw | cb(writer_bits[sel - 1]);
      if ($urandom_range(0, 2) == 0) cw = cw | cb(1);
      if ($urandom_range(0, 2) == 0) cw = cw | cb(5);
      if ($urandom_range(0, 1) == 0) cw = cw | cb(7);
      if ($urandom_range(0, 2) == 0) cw = cw | cb(10);
      cyc(cw, 8'($urandom));
    end

    repeat (3) cyc('0, 8'h00);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
